// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 8-bit binary to two-digit BCD converter (double dabble)
// One conversion takes 8 shift cycles plus one DONE cycle; outputs hold until the next DONE.
module bin2bcd_seq #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  bin_reg;
  logic [11:0] scratch;
  logic [2:0]  cnt;
  logic [11:0] scratch_adj;
  logic [19:0] shifted;
  logic        last_step;
  logic [3:0]  hund_fin;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign scratch_adj = {dabble(scratch[11:8]), dabble(scratch[7:4]), dabble(scratch[3:0])};
  assign shifted     = {scratch_adj, bin_reg} << 1;
  assign last_step   = (cnt == 3'd7);
  assign hund_fin    = shifted[19:16];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg <= '0;
      scratch <= '0;
      cnt     <= '0;
      tens    <= '0;
      ones    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg <= bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {scratch, bin_reg} <= shifted;
          cnt                <= cnt + 3'd1;
          // Results are taken from the value this final step produces, not the stale register.
          if (last_step) begin
            ovf <= (hund_fin != 4'd0);
            if (SAT_EN && (hund_fin != 4'd0)) begin
              tens <= 4'd9;
              ones <= 4'd9;
            end else begin
              tens <= shifted[15:12];
              ones <= shifted[11:8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (saturating and raw instances)
module tb_bin2bcd_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bin;
  logic       busy1, done1, ovf1;
  logic [3:0] tens1, ones1;
  logic       busy0, done0, ovf0;
  logic [3:0] tens0, ones0;

  int checks = 0;
  int errors = 0;
  int cur_bin = 0;

  bin2bcd_seq #(.SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .tens(tens1), .ones(ones1), .ovf(ovf1)
  );

  bin2bcd_seq #(.SAT_EN(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .tens(tens0), .ones(ones0), .ovf(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int t1, o1, v1;
    int t0, o0, v0;
  } vec_t;

  vec_t vecs[6];

  // Expected digits straight from decimal arithmetic: {ovf, tens, ones}.
  function automatic logic [8:0] model(input int b, input bit sat);
    int t, o;
    bit v;
    v = (b > 99);
    if (v && sat) begin
      t = 9;
      o = 9;
    end else begin
      t = (b / 10) % 10;
      o = b % 10;
    end
    return {v, 4'(t), 4'(o)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s bin=%0d actual=%0d expected=%0d", name, cur_bin, act, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input int t1, input int o1, input int v1,
                            input int t0, input int o0, input int v0);
    chk({tag, "_tens_sat"}, tens1, t1);
    chk({tag, "_ones_sat"}, ones1, o1);
    chk({tag, "_ovf_sat"},  ovf1,  v1);
    chk({tag, "_tens_raw"}, tens0, t0);
    chk({tag, "_ones_raw"}, ones0, o0);
    chk({tag, "_ovf_raw"},  ovf0,  v0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy1 | busy0, 0);
    chk({tag, "_done"}, done1 | done0, 0);
    chk_digits(tag, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the DONE->IDLE edge.
  task automatic run_conv(input logic [7:0] b, input int t1, input int o1, input int v1,
                          input int t0, input int o0, input int v0, input bit scramble);
    cur_bin = b;
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk("done_sat", done1, (k == 8) ? 1 : 0);
      chk("done_raw", done0, (k == 8) ? 1 : 0);
      chk("busy_sat", busy1, (k <= 8) ? 1 : 0);
      chk("busy_raw", busy0, (k <= 8) ? 1 : 0);
      if (k >= 8) chk_digits((k == 8) ? "res" : "hold", t1, o1, v1, t0, o0, v0);
      if (scramble) bin = 8'($urandom);
    end
  endtask

  task automatic run_model(input logic [7:0] b, input bit scramble);
    logic [8:0] e1, e0;
    e1 = model(b, 1'b1);
    e0 = model(b, 1'b0);
    run_conv(b, e1[7:4], e1[3:0], e1[8], e0[7:4], e0[3:0], e0[8], scramble);
  endtask

  initial begin
    int n_done;
    int last_cyc;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 8'd0;

    vecs[0] = '{8'd0,   0, 0, 0, 0, 0, 0};
    vecs[1] = '{8'd57,  5, 7, 0, 5, 7, 0};
    vecs[2] = '{8'd99,  9, 9, 0, 9, 9, 0};
    vecs[3] = '{8'd10,  1, 0, 0, 1, 0, 0};
    vecs[4] = '{8'd100, 9, 9, 1, 0, 0, 1};
    vecs[5] = '{8'd255, 9, 9, 1, 5, 5, 1};

    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_conv(vecs[i].b, vecs[i].t1, vecs[i].o1, vecs[i].v1,
               vecs[i].t0, vecs[i].o0, vecs[i].v0, 1'b0);

    for (int i = 0; i < 30; i++) run_model(8'($urandom_range(0, 255)), 1'b1);

    for (int b = 0; b < 256; b++) run_model(8'(b), 1'b1);

    // Start pulses during SHIFT and during DONE must be ignored.
    cur_bin = 42;
    start = 1'b1;
    bin   = 8'd42;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = 8'd13;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == 2 || k == 8) ? 1'b1 : 1'b0;
      chk("ign_done", done1, (k == 8) ? 1 : 0);
      chk("ign_busy", busy1, (k <= 8) ? 1 : 0);
      if (k == 8) chk_digits("ign", 4, 2, 0, 4, 2, 0);
    end
    start = 1'b0;

    // Continuous start: one conversion every 10 cycles.
    cur_bin = 23;
    start = 1'b1;
    bin   = 8'd23;
    n_done   = 0;
    last_cyc = -1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin
        n_done++;
        if (last_cyc >= 0) chk("held_period", c - last_cyc, 10);
        else chk("held_first", c, 8);
        last_cyc = c;
        chk_digits("held", 2, 3, 0, 2, 3, 0);
      end
    end
    chk("held_pulses", n_done, 4);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("held_idle", busy1, 0);

    // Reset during SHIFT aborts immediately, no done pulse follows.
    cur_bin = 200;
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_done", done1 | done0, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_conv(8'd88, 8, 8, 0, 8, 8, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
